// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//   Multi-channel, runtime-programmable integer clock divider. Each channel
//   counts 0..div-1 and produces a registered square wave (div_out) and a
//   one-cycle clock-enable pulse (tick) once per period. The reset divisors
//   are 2,4,8,16,... (saturating at 2^DIV_W-1).
//   New divisors are loaded through a valid/ready config port. They take
//   effect at the channel's period boundary, so there are no runt or
//   stretched pulses.
//
//   Optional build macro: CLKDIV_SYNC_EN adds sync_in. A pulse on sync_in
//   restarts every enabled counter from 0 and applies any pending divisor.
//
// Parameters
//   NCH   : number of channels (1..16)
//   DIV_W : divisor/counter width; legal divisors 2..2^DIV_W-1
//   CH_W  : channel-select width (derived)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-low reset
//   en         per-channel run enable
//   cfg_valid  config request valid
//   cfg_ready  config port can accept this cycle
//   cfg_ch     target channel of the config request
//   cfg_div    new divisor for the target channel
//   cfg_err    one-cycle pulse: the last accepted request was illegal
//   div_out    divided square wave per channel
//   tick       one-cycle pulse per channel period
//   sync_in    phase-align pulse (CLKDIV_SYNC_EN only)

module prog_clock_divider #(
   parameter  int unsigned NCH   = 4,
   parameter  int unsigned DIV_W = 8,
   localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_err,
   output logic [NCH-1:0]   div_out,
   output logic [NCH-1:0]   tick
`ifdef CLKDIV_SYNC_EN
   ,
   input  logic             sync_in
`endif
);

   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

   // Reset divisor for channel i: 2^(i+1), saturated to the counter range.
   function automatic logic [DIV_W-1:0] dflt_div(input int unsigned i);
      if (i + 1 >= DIV_W) return '1;
      return DIV_W'(1) << (i + 1);
   endfunction

   logic [NCH-1:0][DIV_W-1:0] cnt;
   logic [NCH-1:0][DIV_W-1:0] div;
   logic [NCH-1:0][DIV_W-1:0] newdiv;
   logic [NCH-1:0]            pend;

   logic             in_range;
   logic             too_small;
   logic             accept;
   logic [DIV_W-1:0] legal_div;
   logic [NCH-1:0]   hit;
   logic [NCH-1:0]   wrap;
   logic [NCH-1:0]   restart;

   always_comb begin
      in_range  = (32'(cfg_ch) < NCH);
      too_small = (cfg_div < DIV_MIN);
      legal_div = too_small ? DIV_MIN : cfg_div;
      // Out-of-range requests are always accepted so they can be discarded.
      cfg_ready = in_range ? !pend[cfg_ch] : 1'b1;
      accept    = cfg_valid && cfg_ready;
      for (int unsigned i = 0; i < NCH; i++) begin
         hit[i]  = accept && in_range && (32'(cfg_ch) == i);
         wrap[i] = (cnt[i] == div[i] - DIV_W'(1));
`ifdef CLKDIV_SYNC_EN
         restart[i] = wrap[i] || sync_in;
`else
         restart[i] = wrap[i];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt[i]    <= '0;
            div[i]    <= dflt_div(i);
            newdiv[i] <= '0;
         end
         pend    <= '0;
         div_out <= '0;
         tick    <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= accept && (!in_range || too_small);
         for (int unsigned i = 0; i < NCH; i++) begin
            if (!en[i]) begin
               // Idle channel: no period in progress, so divisors apply at once.
               cnt[i]     <= '0;
               div_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
               if (hit[i])
                  div[i] <= legal_div;
               else if (pend[i])
                  div[i] <= newdiv[i];
               pend[i] <= 1'b0;
            end else begin
               div_out[i] <= (cnt[i] >= (div[i] >> 1));
               tick[i]    <= wrap[i];
               if (restart[i]) begin
                  // Period boundary: a request landing here skips the pending stage.
                  cnt[i] <= '0;
                  if (hit[i])
                     div[i] <= legal_div;
                  else if (pend[i])
                     div[i] <= newdiv[i];
                  pend[i] <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] + DIV_W'(1);
                  if (hit[i]) begin
                     pend[i]   <= 1'b1;
                     newdiv[i] <= legal_div;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_prog_clock_divider.sv
`timescale 1ns/1ps
module tb_prog_clock_divider;

   localparam int unsigned NCH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] en = '0;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_div = '0;
   logic       cfg_ready, cfg_err;
   logic [3:0] div_out, tick;
`ifdef CLKDIV_SYNC_EN
   logic       sync_in = 1'b0;
`endif

   // Second instance with a non-power-of-two channel count, so cfg_ch=3 is out of range.
   logic [2:0] en3 = '0;
   logic       cfg_valid3 = 1'b0;
   logic [1:0] cfg_ch3 = '0;
   logic [7:0] cfg_div3 = '0;
   logic       cfg_ready3, cfg_err3;
   logic [2:0] div_out3, tick3;

   prog_clock_divider #(.NCH(4), .DIV_W(8)) dut (
      .clk(clk), .rst(rst), .en(en),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_err(cfg_err), .div_out(div_out), .tick(tick)
`ifdef CLKDIV_SYNC_EN
      , .sync_in(sync_in)
`endif
   );

   prog_clock_divider #(.NCH(3), .DIV_W(8)) dut3 (
      .clk(clk), .rst(rst), .en(en3),
      .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
      .cfg_err(cfg_err3), .div_out(div_out3), .tick(tick3)
`ifdef CLKDIV_SYNC_EN
      , .sync_in(1'b0)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nmis = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is described by the cycle its current period started,
   // its active divisor and an optional queued divisor.
   int  cyc = 0;
   bit  mvalid = 1'b0;
   int  mstart [NCH];
   int  mdiv   [NCH];
   bit  mpend  [NCH];
   int  mnext  [NCH];
   bit  [NCH-1:0] edo, etk;
   bit  eerr;

   function automatic int dflt(input int i);
      int d;
      d = 1 << (i + 1);
      return (d > 255) ? 255 : d;
   endfunction

   function automatic bit mready(input logic [1:0] ch);
      return !mpend[ch];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            mstart[i] = cyc + 1;
            mdiv[i]   = dflt(i);
            mpend[i]  = 1'b0;
            mnext[i]  = 0;
         end
         edo = '0; etk = '0; eerr = 1'b0;
         mvalid = 1'b1;
      end else begin
         bit acc, sy;
         int lv;
         acc  = cfg_valid && mready(cfg_ch);
         lv   = (cfg_div < 8'd2) ? 2 : int'(cfg_div);
         eerr = acc && (cfg_div < 8'd2);
`ifdef CLKDIV_SYNC_EN
         sy = sync_in;
`else
         sy = 1'b0;
`endif
         for (int i = 0; i < NCH; i++) begin
            int ph;
            bit hit, last;
            ph   = cyc - mstart[i];
            hit  = acc && (int'(cfg_ch) == i);
            last = (ph == mdiv[i] - 1);
            if (!en[i]) begin
               edo[i] = 1'b0; etk[i] = 1'b0;
               mstart[i] = cyc + 1;
               if (hit) mdiv[i] = lv; else if (mpend[i]) mdiv[i] = mnext[i];
               mpend[i] = 1'b0;
            end else begin
               edo[i] = (ph >= mdiv[i] / 2);
               etk[i] = last;
               if (last || sy) begin
                  mstart[i] = cyc + 1;
                  if (hit) mdiv[i] = lv; else if (mpend[i]) mdiv[i] = mnext[i];
                  mpend[i] = 1'b0;
               end else if (hit) begin
                  mpend[i] = 1'b1;
                  mnext[i] = lv;
               end
            end
         end
      end
   end

   // Continuous compare against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         check("div_out",   32'(div_out),   32'(edo));
         check("tick",      32'(tick),      32'(etk));
         check("cfg_err",   32'(cfg_err),   32'(eerr));
         check("cfg_ready", 32'(cfg_ready), 32'(mready(cfg_ch)));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input int ch, input string nm);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!tick[ch] && k < 400);
      check(nm, 32'(tick[ch]), 32'd1);
   endtask

   initial begin
      int idx;

      // Reset defaults: outputs mirror a free-running counter with 1-cycle lag.
      rst = 1'b0;
      repeat (3) step();
      check("rst_div_out", 32'(div_out), 32'd0);
      check("rst_tick",    32'(tick),    32'd0);
      rst = 1'b1; en = '1; en3 = '1;
      for (int m = 0; m < 32; m++) begin
         step();
         check("dflt_div_out",  32'(div_out),  32'(m[3:0]));
         check("dflt_tick3",    32'(tick[3]),  32'((m % 16) == 15));
         check("dut3_div_out",  32'(div_out3), 32'(m[2:0]));
         if (m == 9) begin
            cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd9;
            #1 check("oor_ready", 32'(cfg_ready3), 32'd1);
         end
         if (m == 10) begin
            check("oor_err", 32'(cfg_err3), 32'd1);
            cfg_valid3 = 1'b0;
         end
         if (m == 11) check("oor_err_clr", 32'(cfg_err3), 32'd0);
      end

      // Odd divisor on ch0.
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
      #1 check("ch0_ready", 32'(cfg_ready), 32'd1);
      step();
      cfg_valid = 1'b0;
      wait_tick(0, "ch0_apply");
      for (int k = 0; k < 10; k++) begin
         step();
         check("odd_div_out", 32'(div_out[0]), 32'((k % 5) >= 2));
         check("odd_tick",    32'(tick[0]),    32'((k % 5) == 4));
      end

      // Mid-period update on ch2 (div 8) at cnt=3, second request stalls.
      wait_tick(2, "ch2_align");
      repeat (3) step();
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
      #1 check("ch2_ready", 32'(cfg_ready), 32'd1);
      step();
      cfg_div = 8'd5;
      #1 check("ch2_stall", 32'(cfg_ready), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("ch2_old_tick", 32'(tick[2]),   32'(k == 3));
         check("ch2_ready_w",  32'(cfg_ready), 32'(k == 3));
      end
      step();
      cfg_valid = 1'b0;
      #1 check("ch2_pend2", 32'(cfg_ready), 32'd0);
      for (int k = 0; k < 2; k++) begin
         step();
         check("ch2_div3_tick", 32'(tick[2]), 32'(k == 1));
      end
      for (int k = 0; k < 5; k++) begin
         step();
         check("ch2_div5_tick", 32'(tick[2]), 32'(k == 4));
      end

      // Illegal divisor on ch1 is clamped to 2.
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
      #1 check("ch1_ready", 32'(cfg_ready), 32'd1);
      step();
      cfg_valid = 1'b0;
      check("ch1_err", 32'(cfg_err), 32'd1);
      step();
      check("ch1_err_clr", 32'(cfg_err), 32'd0);
      wait_tick(1, "ch1_apply");
      step();
      check("ch1_lo", 32'({div_out[1], tick[1]}), 32'b00);
      step();
      check("ch1_hi", 32'({div_out[1], tick[1]}), 32'b11);

      // Disable ch1 at cnt=1, then re-enable.
      step();
      en[1] = 1'b0;
      step();
      check("dis_out", 32'({div_out[1], tick[1]}), 32'b00);
      repeat (3) step();
      check("dis_hold", 32'({div_out[1], tick[1]}), 32'b00);
      en[1] = 1'b1;
      step();
      check("reen_0", 32'({div_out[1], tick[1]}), 32'b00);
      step();
      check("reen_1", 32'({div_out[1], tick[1]}), 32'b11);

      // Reset while ch3 has a pending update.
      wait_tick(3, "ch3_align");
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
      step();
      cfg_valid = 1'b0;
      #1 check("ch3_pend", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      #1 check("rst_pend_clr", 32'(cfg_ready), 32'd1);
      for (int m = 0; m < 16; m++) begin
         step();
         check("rst_ch3_tick", 32'(tick[3]), 32'(m == 15));
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic acc;
         if ($urandom_range(0, 19) == 0) begin
            idx = $urandom_range(0, 3);
            en[idx] = ~en[idx];
         end
         if (!cfg_valid && $urandom_range(0, 4) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
               0:       cfg_div = 8'($urandom_range(0, 1));
               1:       cfg_div = 8'($urandom_range(13, 60));
               default: cfg_div = 8'($urandom_range(2, 12));
            endcase
         end
         if (n == 1700) rst = 1'b0;
         if (n == 1702) rst = 1'b1;
         #1;
         acc = cfg_valid && cfg_ready;
         step();
         if (acc) cfg_valid = 1'b0;
      end
      cfg_valid = 1'b0;

`ifdef CLKDIV_SYNC_EN
      // Phase alignment: all divisors 4, then a sync pulse.
      en = '1;
      step();
      for (int c = 0; c < 4; c++) begin
         int k;
         cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_div = 8'd4;
         k = 0;
         #1;
         while (!cfg_ready && k < 300) begin
            step();
            k++;
         end
         check("sync_cfg_ready", 32'(cfg_ready), 32'd1);
         step();
         cfg_valid = 1'b0;
      end
      repeat (7) step();
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      for (int m = 0; m < 12; m++) begin
         step();
         check("sync_tick", 32'(tick), ((m % 4) == 3) ? 32'hF : 32'h0);
      end
`endif

      step();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
